// File: rtl/main_mem_pipe.sv
// main_mem_pipe: pipelined main-memory front end with fixed read latency and posted writes.
// Optional misaligned-access rejection enabled by MAIN_MEM_ALIGN_CHK_EN.
module main_mem_pipe #(
  parameter int ADDR_W    = 16,
  parameter int LATENCY   = 4,
  parameter int MEM_WORDS = 32768
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       data_in,
  output logic [15:0]       data_out,
  output logic              data_valid,
  output logic              busy,
  output logic              err
);
  localparam int IW = $clog2(MEM_WORDS);
  logic [15:0]        mem [MEM_WORDS];
  logic [LATENCY-1:0] v_q, v_d;
  logic [15:0]        d_q [LATENCY];
  logic [15:0]        d_d [LATENCY];
  logic [3:0]         cnt_q, cnt_d;
  logic               err_q, err_d;
  logic               ok, rd, we;
  logic [IW-1:0]      idx;
  logic               unused_addr;
  assign idx         = addr[IW:1];
  assign unused_addr = ^addr;
`ifdef MAIN_MEM_ALIGN_CHK_EN
  assign ok    = enable & ~addr[0];
  assign err_d = enable & addr[0];
`else
  assign ok    = enable;
  assign err_d = 1'b0;
`endif
  assign rd = ok & ~wr;
  assign we = ok & wr;
  // Data stages only advance behind a valid bit so data_out holds its last result.
  always_comb begin
    v_d    = LATENCY'({v_q, rd});
    d_d[0] = rd ? mem[idx] : d_q[0];
    for (int k = 1; k < LATENCY; k++) d_d[k] = v_q[k-1] ? d_q[k-1] : d_q[k];
    cnt_d  = cnt_q + 4'(rd) - 4'(v_q[LATENCY-1]);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q   <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
      for (int k = 0; k < LATENCY; k++) d_q[k] <= '0;
    end else begin
      v_q   <= v_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
      for (int k = 0; k < LATENCY; k++) d_q[k] <= d_d[k];
    end
  end
  always_ff @(posedge clk) begin
    if (we) mem[idx] <= data_in;
  end
  assign data_out   = d_q[LATENCY-1];
  assign data_valid = v_q[LATENCY-1];
  assign busy       = |v_q;
  assign err        = err_q;
  a_cnt: assert property (@(posedge clk) disable iff (!rst_n) cnt_q == 4'($countones(v_q)));
endmodule

// File: tb/tb_main_mem_pipe.sv
// tb_main_mem_pipe: directed scoreboard bench for main_mem_pipe (MEM_WORDS=16 to exercise wrap).
module tb_main_mem_pipe;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable = 1'b0;
  logic        wr = 1'b0;
  logic [15:0] addr = '0;
  logic [15:0] data_in = '0;
  logic [15:0] data_out;
  logic        data_valid, busy, err;
  logic [15:0] exp_q [$];
  int          checks = 0;
  int          errors = 0;
  int          run = 0;
  int          max_run = 0;
  int          dv_cnt = 0;
  int          peak = 0;
  int          dv_snap;
  logic        al;
  main_mem_pipe #(.ADDR_W(16), .LATENCY(4), .MEM_WORDS(16)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .wr(wr), .addr(addr),
    .data_in(data_in), .data_out(data_out), .data_valid(data_valid),
    .busy(busy), .err(err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", n, got, want, $time);
    end
  endtask
  task automatic req(input logic w, input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    enable = 1'b1; wr = w; addr = a; data_in = d;
  endtask
  task automatic rd(input logic [15:0] a, input logic [15:0] e);
    req(1'b0, a, 16'h0);
    exp_q.push_back(e);
  endtask
  task automatic idle();
    @(negedge clk);
    enable = 1'b0; wr = 1'b0;
  endtask
  always @(negedge clk) begin
    if (data_valid) begin
      run++;
      dv_cnt++;
      if (run > max_run) max_run = run;
      if (exp_q.size() == 0) chk("dv_unexpected", 16'(data_valid), 16'h0);
      else chk("rdata", data_out, exp_q.pop_front());
    end else run = 0;
    if (int'(dut.cnt_q) > peak) peak = int'(dut.cnt_q);
  end
  initial begin
`ifdef MAIN_MEM_ALIGN_CHK_EN
    al = 1'b1;
`else
    al = 1'b0;
`endif
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_data_out", data_out, 16'h0);
    chk("rst_dv", 16'(data_valid), 16'h0);
    chk("rst_busy", 16'(busy), 16'h0);
    chk("rst_err", 16'(err), 16'h0);
    rst_n = 1'b1;
    // single read: data_valid in cycle 4, busy in cycles 1..4
    req(1'b1, 16'h0010, 16'hBEEF);
    rd(16'h0010, 16'hBEEF);
    for (int c = 1; c <= 5; c++) begin
      idle();
      chk($sformatf("t1_busy_c%0d", c), 16'(busy), 16'(c <= 4));
      chk($sformatf("t1_dv_c%0d", c), 16'(data_valid), 16'(c == 4));
    end
    // burst of 8 back-to-back reads
    for (int i = 0; i < 8; i++) req(1'b1, 16'h0100 + 16'(2 * i), 16'h1000 + 16'(i));
    max_run = 0;
    peak = 0;
    for (int i = 0; i < 8; i++) rd(16'h0100 + 16'(2 * i), 16'h1000 + 16'(i));
    repeat (8) idle();
    chk("burst_run", 16'(max_run), 16'd8);
    chk("burst_peak", 16'(peak), 16'd4);
    chk("burst_cnt_end", 16'(dut.cnt_q), 16'd0);
    chk("burst_busy_end", 16'(busy), 16'h0);
    // snapshot ordering
    req(1'b1, 16'h0200, 16'h1111);
    rd(16'h0200, 16'h1111);
    req(1'b1, 16'h0200, 16'h2222);
    rd(16'h0200, 16'h2222);
    repeat (6) idle();
    // reset with three reads in flight
    req(1'b1, 16'h0004, 16'h5A5A);
    for (int i = 0; i < 3; i++) req(1'b0, 16'h0004, 16'h0);
    idle();
    @(posedge clk);
    #2;
    chk("pre_rst_dv", 16'(data_valid), 16'h1);
    dv_snap = dv_cnt;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_dv", 16'(data_valid), 16'h0);
    chk("mid_rst_busy", 16'(busy), 16'h0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (8) idle();
    chk("post_rst_dv_cnt", 16'(dv_cnt), 16'(dv_snap));
    chk("post_rst_busy", 16'(busy), 16'h0);
    rd(16'h0004, 16'h5A5A);
    repeat (6) idle();
    // word index wraps at MEM_WORDS
    req(1'b1, 16'h0002, 16'hAAAA);
    rd(16'h0022, 16'hAAAA);
    repeat (6) idle();
    // misaligned accesses
    req(1'b1, 16'h0030, 16'h3030);
    req(1'b1, 16'h0031, 16'hDEAD);
    idle();
    chk("mis_wr_err", 16'(err), 16'(al));
    idle();
    chk("mis_wr_err_clr", 16'(err), 16'h0);
    if (al) req(1'b0, 16'h0031, 16'h0);
    else rd(16'h0031, 16'hDEAD);
    idle();
    chk("mis_rd_err", 16'(err), 16'(al));
    idle();
    chk("mis_rd_err_clr", 16'(err), 16'h0);
    rd(16'h0030, al ? 16'h3030 : 16'hDEAD);
    repeat (8) idle();
    chk("queue_empty", 16'(exp_q.size()), 16'h0);
    chk("end_busy", 16'(busy), 16'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
